// File: rtl/lfsr_multi_pkg.sv
// lfsr_multi_pkg.sv -- shared constants and types for the lfsr_multi generator.
// Holds the per-channel reset seeds, XNOR tap masks and the control-state enum.
package lfsr_pkg;

   localparam int MAX_CH = 8;

   // Reset state of each channel; index 0 is channel 0.
   localparam logic [0:MAX_CH-1][31:0] SEED = {
      32'h6BF2_7D49,
      32'hBB23_AF11,
      32'hAAAA_AAAA,
      32'h123F_ED00,
      32'hABFC_1533,
      32'h84FA_BDE1,
      32'h129F_BBC6,
      32'hBAC9_6E50
   };

   // Four-tap feedback masks; a set bit means that state bit feeds the XNOR.
   localparam logic [0:MAX_CH-1][31:0] TAP = {
      32'h4040_2020,   // {30,22,13,5}
      32'h0801_0084,   // {27,16,7,2}
      32'h0010_D000,   // {20,15,14,12}
      32'h2400_000C,   // {29,26,3,2}
      32'h8004_0402,   // {31,18,10,1}
      32'h0082_0140,   // {23,17,8,6}
      32'h4060_0020,   // {30,22,21,5}
      32'h0108_0210    // {24,19,9,4}
   };

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_HOLD
   } ctrlState_e;

   // Fill counter width; a single-step word still keeps a one-bit counter.
   function automatic int cntWidth(input int steps);
      return (steps > 1) ? $clog2(steps) : 1;
   endfunction

endpackage

// File: rtl/lfsr_multi_if.sv
// lfsr_multi_if.sv -- valid/ready word channel between the generator and its consumer.
// The generator side uses the master modport, the consumer side the slave modport.
interface lfsr_multi_if #(
   parameter int OUT_W = 8
);
   logic             rnd_valid;
   logic             rnd_ready;
   logic [OUT_W-1:0] rnd_data;

   modport master (
      output rnd_valid,
      output rnd_data,
      input  rnd_ready
   );

   modport slave (
      input  rnd_valid,
      input  rnd_data,
      output rnd_ready
   );
endinterface

// File: rtl/lfsr_multi_chan.sv
// lfsr_multi_chan.sv -- one 32-bit XNOR LFSR channel (module lfsr_chan).
// A load always beats a step. When LFSR_LOCKUP_RECOVER_EN is defined, a step taken
// from the all-ones lockup state reloads SEED instead of shifting and raises recover_o.
module lfsr_chan #(
   parameter logic [31:0] SEED = 32'h0000_0001,
   parameter logic [31:0] TAP  = 32'h8000_0001
) (
   input  logic        clk,
   input  logic        rst,
`ifdef LFSR_LOCKUP_RECOVER_EN
   output logic        recover_o,
`endif
   input  logic        step_i,
   input  logic        load_i,
   input  logic [31:0] loadData_i,
   output logic        fb_o
);

   logic [31:0] state_q;
   logic [31:0] state_d;

   assign fb_o = ~^(state_q & TAP);

`ifdef LFSR_LOCKUP_RECOVER_EN
   // Next state: load wins, then lockup recovery, then a normal shift.
   always_comb begin
      state_d   = state_q;
      recover_o = 1'b0;
      if (load_i) begin
         state_d = loadData_i;
      end else if (step_i) begin
         if (state_q == 32'hFFFF_FFFF) begin
            state_d   = SEED;
            recover_o = 1'b1;
         end else begin
            state_d = {state_q[30:0], fb_o};
         end
      end
   end
`else
   // Next state: load wins over a shift; all-ones is left to lock up.
   always_comb begin
      state_d = state_q;
      if (load_i) begin
         state_d = loadData_i;
      end else if (step_i) begin
         state_d = {state_q[30:0], fb_o};
      end
   end
`endif

   // Channel state register, reset to its own seed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

endmodule

// File: rtl/lfsr_multi.sv
// lfsr_multi.sv -- multi-channel XNOR-LFSR random-word generator with valid/ready output.
// N_CH channels each contribute one bit per step; OUT_W/N_CH steps build one word.
// Optional feature macro: LFSR_LOCKUP_RECOVER_EN (all-ones recovery plus lockup pulse).
module lfsr_multi
   import lfsr_pkg::*;
#(
   parameter int N_CH  = 8,
   parameter int OUT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                seed_we,
   input  logic [2:0]          seed_ch,
   input  logic [31:0]         seed_data,
   lfsr_multi_if.master        rnd,
   output logic                lockup
);

   localparam int STEPS = OUT_W / N_CH;
   localparam int CW    = cntWidth(STEPS);

   ctrlState_e       state_q;
   ctrlState_e       state_d;

   logic             stepEn;
   logic             lastStep;
   logic             seedHit;
   logic [N_CH-1:0]  fbVec;
   logic [N_CH-1:0]  loadVec;
   logic [OUT_W-1:0] wsrShift;

   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic [OUT_W-1:0] wsr_q;
   logic [OUT_W-1:0] wsr_d;
   logic [OUT_W-1:0] rndData_q;
   logic [OUT_W-1:0] rndData_d;
   logic             rndValid_q;
   logic             rndValid_d;

`ifdef LFSR_LOCKUP_RECOVER_EN
   logic [N_CH-1:0]  recoverVec;
   logic             lockup_q;
`endif

   // A seed write only disturbs the word assembly when it targets a real channel.
   assign seedHit = seed_we && ({1'b0, seed_ch} < 4'(N_CH));

   for (genvar c = 0; c < N_CH; c++) begin : gCh
      assign loadVec[c] = seed_we && (seed_ch == 3'(c));

      lfsr_chan #(
         .SEED (SEED[c]),
         .TAP  (TAP[c])
      ) uChan (
         .clk        (clk),
         .rst        (rst),
`ifdef LFSR_LOCKUP_RECOVER_EN
         .recover_o  (recoverVec[c]),
`endif
         .step_i     (stepEn),
         .load_i     (loadVec[c]),
         .loadData_i (seed_data),
         .fb_o       (fbVec[c])
      );
   end

   // The newest step slice always lands in the low N_CH bits of the word.
   if (STEPS == 1) begin : gWsrOne
      assign wsrShift = fbVec;
   end else begin : gWsrMulti
      assign wsrShift = {wsr_q[OUT_W-N_CH-1:0], fbVec};
   end

   // Control state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Control next state: dropping enable always idles, a stalled word parks in HOLD.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (en) state_d = ST_FILL;
         end
         ST_FILL: begin
            if (!en) state_d = ST_IDLE;
            else if (rndValid_d && !rnd.rnd_ready) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (!en) state_d = ST_IDLE;
            else if (rnd.rnd_ready) state_d = ST_FILL;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control outputs: step only when enabled, not seeding, and the output slot is free.
   always_comb begin
      stepEn   = en && !seed_we && (!rndValid_q || rnd.rnd_ready);
      lastStep = (cnt_q == CW'(STEPS - 1));
   end

   // Word assembly and output slot; a completing step refills the slot during a transfer.
   always_comb begin
      cnt_d      = cnt_q;
      wsr_d      = wsr_q;
      rndData_d  = rndData_q;
      rndValid_d = rndValid_q;
      if (seedHit) begin
         cnt_d = '0;
         wsr_d = '0;
      end else if (stepEn) begin
         wsr_d = wsrShift;
         cnt_d = lastStep ? '0 : cnt_q + 1'b1;
      end
      if (stepEn && lastStep) begin
         rndValid_d = 1'b1;
         rndData_d  = wsrShift;
      end else if (rndValid_q && rnd.rnd_ready) begin
         rndValid_d = 1'b0;
      end
   end

   // Datapath registers; reset drops both the partial word and any pending word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         wsr_q      <= '0;
         rndData_q  <= '0;
         rndValid_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         wsr_q      <= wsr_d;
         rndData_q  <= rndData_d;
         rndValid_q <= rndValid_d;
      end
   end

   assign rnd.rnd_valid = rndValid_q;
   assign rnd.rnd_data  = rndData_q;

`ifdef LFSR_LOCKUP_RECOVER_EN
   // One-cycle lockup flag raised alongside any channel's recovery reload.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lockup_q <= 1'b0;
      end else begin
         lockup_q <= |recoverVec;
      end
   end

   assign lockup = lockup_q;
`else
   assign lockup = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_multi.sv
// tb_lfsr_multi.sv -- directed bench for lfsr_multi.
// dutA is the default 8-channel/8-bit build, dutB assembles 16-bit words in two steps.
// Expectations come from an independent behavioural LFSR model built from tap positions.
module tb_lfsr_multi;

   logic        clk;
   logic        rst;

   logic        enA, weA, lockA;
   logic [2:0]  chA;
   logic [31:0] sdA;
   logic        enB, weB, lockB;
   logic [2:0]  chB;
   logic [31:0] sdB;

   lfsr_multi_if #(.OUT_W(8))  ifA ();
   lfsr_multi_if #(.OUT_W(16)) ifB ();

   lfsr_multi #(.N_CH(8), .OUT_W(8)) dutA (
      .clk       (clk),
      .rst       (rst),
      .en        (enA),
      .seed_we   (weA),
      .seed_ch   (chA),
      .seed_data (sdA),
      .rnd       (ifA),
      .lockup    (lockA)
   );

   lfsr_multi #(.N_CH(8), .OUT_W(16)) dutB (
      .clk       (clk),
      .rst       (rst),
      .en        (enB),
      .seed_we   (weB),
      .seed_ch   (chB),
      .seed_data (sdB),
      .rnd       (ifB),
      .lockup    (lockB)
   );

   int checkCount = 0;
   int errorCount = 0;

   logic [31:0] seedTab [8] = '{32'h6BF2_7D49, 32'hBB23_AF11, 32'hAAAA_AAAA, 32'h123F_ED00,
                                32'hABFC_1533, 32'h84FA_BDE1, 32'h129F_BBC6, 32'hBAC9_6E50};
   logic [31:0] mA [8];
   logic [31:0] mB [8];
   logic [7:0]  sl, lastA, s1, s2, s3, s4, s5, s6, sA, sB, sC;
   logic        rec;

   // 100 MHz style free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] tapMask(input int c);
      int          pos [4];
      logic [31:0] m;
      case (c)
         0: pos = '{30, 22, 13, 5};
         1: pos = '{27, 16, 7, 2};
         2: pos = '{20, 15, 14, 12};
         3: pos = '{29, 26, 3, 2};
         4: pos = '{31, 18, 10, 1};
         5: pos = '{23, 17, 8, 6};
         6: pos = '{30, 22, 21, 5};
         default: pos = '{24, 19, 9, 4};
      endcase
      m = '0;
      for (int k = 0; k < 4; k++) m[pos[k]] = 1'b1;
      return m;
   endfunction

   // One model step for all eight channels; returns the step slice.
   task automatic advance(input logic [31:0] cur [8], output logic [31:0] nxt [8],
                          output logic [7:0] slice, output logic recovered);
      recovered = 1'b0;
      for (int c = 0; c < 8; c++) begin
         slice[c] = ~^(cur[c] & tapMask(c));
`ifdef LFSR_LOCKUP_RECOVER_EN
         if (cur[c] == 32'hFFFF_FFFF) begin
            nxt[c]    = seedTab[c];
            recovered = 1'b1;
         end else
`endif
         nxt[c] = {cur[c][30:0], slice[c]};
      end
   endtask

   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp)
      else begin
         errorCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Linear directed sequence: reset, streaming, backpressure, idle, lockup, multi-step, reseed, reset.
   initial begin
      rst = 1'b1;
      enA = 1'b0; weA = 1'b0; chA = '0; sdA = '0;
      enB = 1'b0; weB = 1'b0; chB = '0; sdB = '0;
      ifA.rnd_ready = 1'b1;
      ifB.rnd_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         mA[c] = seedTab[c];
         mB[c] = seedTab[c];
      end

      #2;
      checkOutput("rstValidA", ifA.rnd_valid, 32'd0);
      checkOutput("rstDataA", ifA.rnd_data, 32'd0);
      checkOutput("rstLockA", lockA, 32'd0);
      checkOutput("rstStateA0", dutA.gCh[0].uChan.state_q, 32'h6BF2_7D49);
      checkOutput("rstDataB", ifB.rnd_data, 32'd0);

      applyStimulus(1);
      rst = 1'b0;
      enA = 1'b1;

      $display("[TB] streaming one word per cycle on dutA");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1);
         advance(mA, mA, sl, rec);
         lastA = sl;
         checkOutput("wordA", ifA.rnd_data, sl);
         checkOutput("validA", ifA.rnd_valid, 32'd1);
         checkOutput("stateA0", dutA.gCh[0].uChan.state_q, mA[0]);
      end

      $display("[TB] backpressure on dutA");
      ifA.rnd_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1);
         checkOutput("holdDataA", ifA.rnd_data, lastA);
         checkOutput("holdValidA", ifA.rnd_valid, 32'd1);
         checkOutput("holdStateA0", dutA.gCh[0].uChan.state_q, mA[0]);
      end
      ifA.rnd_ready = 1'b1;
      applyStimulus(1);
      advance(mA, mA, sl, rec);
      lastA = sl;
      checkOutput("resumeDataA", ifA.rnd_data, sl);
      checkOutput("resumeValidA", ifA.rnd_valid, 32'd1);

      $display("[TB] enable low freezes dutA");
      enA = 1'b0;
      applyStimulus(2);
      checkOutput("idleDataA", ifA.rnd_data, lastA);
      checkOutput("idleValidA", ifA.rnd_valid, 32'd0);
      checkOutput("idleStateA0", dutA.gCh[0].uChan.state_q, mA[0]);

      $display("[TB] all-ones seed on dutA channel 0");
      enA = 1'b1;
      weA = 1'b1; chA = 3'd0; sdA = 32'hFFFF_FFFF;
      applyStimulus(1);
      mA[0] = 32'hFFFF_FFFF;
      checkOutput("lockSeedA0", dutA.gCh[0].uChan.state_q, mA[0]);
      checkOutput("lockSeedValidA", ifA.rnd_valid, 32'd0);
      weA = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1);
         advance(mA, mA, sl, rec);
         checkOutput("lockDataA", ifA.rnd_data, sl);
         checkOutput("lockStateA0", dutA.gCh[0].uChan.state_q, mA[0]);
         checkOutput("lockPulseA", lockA, rec);
      end
      enA = 1'b0;

      $display("[TB] two-step words on dutB");
      enB = 1'b1;
      applyStimulus(1);
      advance(mB, mB, s1, rec);
      checkOutput("fill1ValidB", ifB.rnd_valid, 32'd0);
      applyStimulus(1);
      advance(mB, mB, s2, rec);
      checkOutput("word1B", ifB.rnd_data, {s1, s2});
      checkOutput("word1ValidB", ifB.rnd_valid, 32'd1);
      applyStimulus(1);
      advance(mB, mB, s3, rec);
      checkOutput("fill2ValidB", ifB.rnd_valid, 32'd0);
      applyStimulus(1);
      advance(mB, mB, s4, rec);
      checkOutput("word2B", ifB.rnd_data, {s3, s4});
      checkOutput("word2ValidB", ifB.rnd_valid, 32'd1);

      $display("[TB] reseed dutB with a word pending");
      ifB.rnd_ready = 1'b0;
      weB = 1'b1; chB = 3'd0; sdB = 32'h0000_0001;
      applyStimulus(1);
      mB[0] = 32'h0000_0001;
      checkOutput("seedKeepValidB", ifB.rnd_valid, 32'd1);
      checkOutput("seedKeepDataB", ifB.rnd_data, {s3, s4});
      checkOutput("seedStateB0", dutB.gCh[0].uChan.state_q, 32'h0000_0001);
      weB = 1'b0;
      ifB.rnd_ready = 1'b1;
      applyStimulus(1);
      advance(mB, mB, s5, rec);
      checkOutput("seedXferValidB", ifB.rnd_valid, 32'd0);
      applyStimulus(1);
      advance(mB, mB, s6, rec);
      checkOutput("word3B", ifB.rnd_data, {s5, s6});
      checkOutput("seedFbBitB", ifB.rnd_data[8], 32'd1);
      checkOutput("seedShiftB0", dutB.gCh[0].uChan.state_q, mB[0]);

      $display("[TB] reseed dutB mid-word");
      applyStimulus(1);
      advance(mB, mB, sA, rec);
      checkOutput("partValidB", ifB.rnd_valid, 32'd0);
      weB = 1'b1; chB = 3'd0; sdB = 32'h0000_0001;
      applyStimulus(1);
      mB[0] = 32'h0000_0001;
      checkOutput("abortValidB", ifB.rnd_valid, 32'd0);
      weB = 1'b0;
      applyStimulus(1);
      advance(mB, mB, sB, rec);
      checkOutput("refillValidB", ifB.rnd_valid, 32'd0);
      applyStimulus(1);
      advance(mB, mB, sC, rec);
      checkOutput("word4B", ifB.rnd_data, {sB, sC});
      checkOutput("word4ValidB", ifB.rnd_valid, 32'd1);

      $display("[TB] asynchronous reset with words pending");
      ifB.rnd_ready = 1'b0;
      enA = 1'b1;
      applyStimulus(1);
      checkOutput("preRstValidB", ifB.rnd_valid, 32'd1);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("arstValidA", ifA.rnd_valid, 32'd0);
      checkOutput("arstDataA", ifA.rnd_data, 32'd0);
      checkOutput("arstValidB", ifB.rnd_valid, 32'd0);
      checkOutput("arstDataB", ifB.rnd_data, 32'd0);
      checkOutput("arstLockA", lockA, 32'd0);
      checkOutput("arstStateA0", dutA.gCh[0].uChan.state_q, seedTab[0]);
      checkOutput("arstStateB0", dutB.gCh[0].uChan.state_q, seedTab[0]);
      checkOutput("arstStateB1", dutB.gCh[1].uChan.state_q, seedTab[1]);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
